// File: rtl/down_count_monitor.sv
// down_count_monitor
// Consumer stage that sits directly behind a W-bit synchronous down counter.
// It samples the count, confirms it follows a legal decrement sequence
// (all-ones preload, 0 -> all-ones wrap), and reports a terminal-count
// pulse, a wrap counter, a lock flag and error statistics.
// Lock is declared after LOCK_CNT consecutive correct decrements; errors are
// only recorded once lock has been established.

module down_count_monitor #(
  parameter int W        = 4,
  parameter int LOCK_CNT = 3,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W-1:0]      q_in,
  input  logic              in_valid,
  input  logic              clear_err,
  output logic              locked,
  output logic              tc_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count
);

  // Match counter is wide enough for the full LOCK_CNT range (1..15).
  localparam int MC_W = 4;

  localparam logic [W-1:0]      ZERO_W     = {W{1'b0}};
  localparam logic [W-1:0]      ONE_W      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]      ALL_ONES_W = {W{1'b1}};
  localparam logic [MC_W-1:0]   ZERO_MC    = {MC_W{1'b0}};
  localparam logic [MC_W-1:0]   ONE_MC     = {{(MC_W-1){1'b0}}, 1'b1};
  localparam logic [MC_W-1:0]   LOCK_VAL   = MC_W'(LOCK_CNT);
  localparam logic [WRAP_W-1:0] ZERO_WRAP  = {WRAP_W{1'b0}};
  localparam logic [WRAP_W-1:0] ONE_WRAP   = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ZERO_ERR   = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0]  ONE_ERR    = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  MAX_ERR    = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Value the upstream counter must present next: one below the last sample,
  // wrapping naturally from 0 to all-ones.
  function automatic logic [W-1:0] expected_next(input logic [W-1:0] prev_val);
    return prev_val - ONE_W;
  endfunction

  // Error counter increment that sticks at all-ones instead of rolling over.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
    logic [ERR_W-1:0] res;
    if (cnt == MAX_ERR) begin
      res = MAX_ERR;
    end else begin
      res = cnt + ONE_ERR;
    end
    return res;
  endfunction

  // Tracking state
  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    prev_r;
  logic [MC_W-1:0] match_cnt_r;
  logic [MC_W-1:0] match_cnt_s;

  // Decode of the current sample
  logic [W-1:0]    expected_s;
  logic            is_match_s;
  logic            seq_break_s;

  // Next values of the registered outputs
  logic              locked_s;
  logic              tc_pulse_s;
  logic [WRAP_W-1:0] wrap_count_s;
  logic              err_sticky_s;
  logic [ERR_W-1:0]  err_count_s;

  assign expected_s = expected_next(prev_r);
  assign is_match_s = (q_in == expected_s);

  // State register plus the tracking context (last sample and match count).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_UNLOCKED;
      prev_r      <= ZERO_W;
      match_cnt_r <= ZERO_MC;
    end else begin
      state_r     <= state_s;
      match_cnt_r <= match_cnt_s;
      if (in_valid) begin
        prev_r <= q_in;
      end else begin
        prev_r <= prev_r;
      end
    end
  end

  // Next-state logic: acquisition counting, lock entry and loss of lock.
  always_comb begin
    state_s     = state_r;
    match_cnt_s = match_cnt_r;
    seq_break_s = 1'b0;
    if (in_valid) begin
      case (state_r)
        ST_UNLOCKED: begin
          // First sample only seeds prev; nothing to compare against yet.
          state_s     = ST_ACQUIRE;
          match_cnt_s = ZERO_MC;
        end
        ST_ACQUIRE: begin
          if (is_match_s) begin
            if ((match_cnt_r + ONE_MC) >= LOCK_VAL) begin
              state_s     = ST_LOCKED;
              match_cnt_s = ZERO_MC;
            end else begin
              state_s     = ST_ACQUIRE;
              match_cnt_s = match_cnt_r + ONE_MC;
            end
          end else begin
            // Mismatch while acquiring just restarts the run; not an error.
            state_s     = ST_ACQUIRE;
            match_cnt_s = ZERO_MC;
          end
        end
        ST_LOCKED: begin
          if (is_match_s) begin
            state_s     = ST_LOCKED;
            match_cnt_s = match_cnt_r;
          end else begin
            // A held value also lands here since it differs from prev-1.
            state_s     = ST_ACQUIRE;
            match_cnt_s = ZERO_MC;
            seq_break_s = 1'b1;
          end
        end
        default: begin
          state_s     = ST_UNLOCKED;
          match_cnt_s = ZERO_MC;
        end
      endcase
    end else begin
      state_s     = state_r;
      match_cnt_s = match_cnt_r;
    end
  end

  // Output logic: next values for tc, wrap, lock and error statistics.
  always_comb begin
    locked_s     = (state_s == ST_LOCKED);
    tc_pulse_s   = 1'b0;
    wrap_count_s = wrap_count;
    err_sticky_s = err_sticky;
    err_count_s  = err_count;

    // Terminal count and wrap only count on a correct sample taken while
    // already locked; the edge that achieves lock does not qualify.
    if (in_valid && (state_r == ST_LOCKED) && is_match_s) begin
      if (q_in == ZERO_W) begin
        tc_pulse_s = 1'b1;
      end else begin
        tc_pulse_s = 1'b0;
      end
      if ((prev_r == ZERO_W) && (q_in == ALL_ONES_W)) begin
        wrap_count_s = wrap_count + ONE_WRAP;
      end else begin
        wrap_count_s = wrap_count;
      end
    end else begin
      tc_pulse_s   = 1'b0;
      wrap_count_s = wrap_count;
    end

    // A new break takes priority over a simultaneous clear: the clear
    // wipes history, then the fresh break is recorded as the first one.
    if (seq_break_s) begin
      err_sticky_s = 1'b1;
      if (clear_err) begin
        err_count_s = ONE_ERR;
      end else begin
        err_count_s = sat_inc(err_count);
      end
    end else if (clear_err) begin
      err_sticky_s = 1'b0;
      err_count_s  = ZERO_ERR;
    end else begin
      err_sticky_s = err_sticky;
      err_count_s  = err_count;
    end
  end

  // Output registers: everything visible downstream comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked     <= 1'b0;
      tc_pulse   <= 1'b0;
      wrap_count <= ZERO_WRAP;
      err_sticky <= 1'b0;
      err_count  <= ZERO_ERR;
    end else begin
      locked     <= locked_s;
      tc_pulse   <= tc_pulse_s;
      wrap_count <= wrap_count_s;
      err_sticky <= err_sticky_s;
      err_count  <= err_count_s;
    end
  end

endmodule

// File: tb/tb_down_count_monitor.sv
// Self-checking bench for down_count_monitor (W=4, LOCK_CNT=3, WRAP_W=8,
// ERR_W=4). A table of {input, expected output} records covers acquisition,
// terminal count, wrap, loss and regain of lock, gaps and held values;
// hand-written sequences cover error saturation, clear priority and a
// mid-stream asynchronous reset.

module tb_down_count_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;
  logic       in_valid;
  logic       clear_err;
  logic       locked;
  logic       tc_pulse;
  logic [7:0] wrap_count;
  logic       err_sticky;
  logic [3:0] err_count;

  typedef struct packed {
    logic       l;
    logic       tc;
    logic [7:0] w;
    logic       s;
    logic [3:0] c;
  } exp_t;

  typedef struct {
    logic [3:0] q;
    logic       v;
    logic       clr;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  down_count_monitor #(
    .W(4), .LOCK_CNT(3), .WRAP_W(8), .ERR_W(4)
  ) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .in_valid(in_valid),
    .clear_err(clear_err), .locked(locked), .tc_pulse(tc_pulse),
    .wrap_count(wrap_count), .err_sticky(err_sticky), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic l, input logic tc, input int w,
                              input logic s, input int c);
    exp_t e;
    e.l  = l;
    e.tc = tc;
    e.w  = 8'(w);
    e.s  = s;
    e.c  = 4'(c);
    return e;
  endfunction

  function automatic void add(input int q, input logic v, input logic clr,
                              input logic l, input logic tc, input int w,
                              input logic s, input int c);
    vec_t r;
    r.q   = 4'(q);
    r.v   = v;
    r.clr = clr;
    r.e   = mk(l, tc, w, s, c);
    tbl.push_back(r);
  endfunction

  // Consecutive legal decrements from hi down to lo, all with the same outputs.
  function automatic void add_run(input int hi, input int lo, input logic l,
                                  input int w, input logic s, input int c);
    for (int k = hi; k >= lo; k--) begin
      add(k, 1'b1, 1'b0, l, 1'b0, w, s, c);
    end
  endfunction

  task automatic check_now(input exp_t e, input string nm);
    exp_t act;
    act = {locked, tc_pulse, wrap_count, err_sticky, err_count};
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: actual l=%0b tc=%0b w=%0d s=%0b c=%0d required l=%0b tc=%0b w=%0d s=%0b c=%0d",
               nm, act.l, act.tc, act.w, act.s, act.c, e.l, e.tc, e.w, e.s, e.c);
    end
  endtask

  // Drive one sample, queue its expectation, pop and compare after the edge.
  task automatic step(input int q, input logic v, input logic clr,
                      input exp_t e, input string nm);
    exp_t got;
    @(negedge clk);
    q_in      = 4'(q);
    in_valid  = v;
    clear_err = clr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: actual=empty scoreboard required=one entry", nm);
    end else begin
      got = exp_q.pop_front();
      check_now(got, nm);
    end
  endtask

  initial begin
    int sat;
    // Table: expected outputs after the edge sampling each input.
    add(15, 1, 0, 0, 0, 0, 0, 0);   // seeds prev, starts acquisition
    add(14, 1, 0, 0, 0, 0, 0, 0);
    add(13, 1, 0, 0, 0, 0, 0, 0);
    add(12, 1, 0, 1, 0, 0, 0, 0);   // third correct decrement -> locked
    add_run(11, 9, 1, 0, 0, 0);
    add(3, 0, 0, 1, 0, 0, 0, 0);    // three invalid gaps between 9 and 8
    add(3, 0, 0, 1, 0, 0, 0, 0);
    add(3, 0, 0, 1, 0, 0, 0, 0);
    add_run(8, 1, 1, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 0, 0);    // terminal count
    add(15, 1, 0, 1, 0, 1, 0, 0);   // wrap
    add_run(14, 7, 1, 1, 0, 0);
    add(4, 1, 0, 0, 0, 1, 1, 1);    // break at 7 -> 4
    add(3, 1, 0, 0, 0, 1, 1, 1);
    add(2, 1, 0, 0, 0, 1, 1, 1);
    add(1, 1, 0, 1, 0, 1, 1, 1);    // relocked
    add(0, 1, 0, 1, 1, 1, 1, 1);
    add(15, 1, 0, 1, 0, 2, 1, 1);
    add(14, 1, 0, 1, 0, 2, 1, 1);
    add(14, 1, 0, 0, 0, 2, 1, 2);   // held value while locked
    add(13, 1, 0, 0, 0, 2, 1, 2);
    add(12, 1, 0, 0, 0, 2, 1, 2);
    add(11, 1, 0, 1, 0, 2, 1, 2);
    add_run(10, 5, 1, 2, 1, 2);
    add(5, 1, 0, 0, 0, 2, 1, 3);    // 5,5: one error
    add(5, 1, 0, 0, 0, 2, 1, 3);    // repeated while acquiring: no error
    add(4, 1, 0, 0, 0, 2, 1, 3);
    add(3, 1, 0, 0, 0, 2, 1, 3);
    add(2, 1, 0, 1, 0, 2, 1, 3);
    add(0, 1, 0, 0, 0, 2, 1, 4);    // wrong 0: no tc on a mismatch
    add(15, 1, 0, 0, 0, 2, 1, 4);   // 0->15 while acquiring: no wrap
    add(14, 1, 1, 0, 0, 2, 0, 0);   // clear alone
    add(13, 1, 0, 1, 0, 2, 0, 0);

    reset     = 1'b1;
    q_in      = 4'd0;
    in_valid  = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now(mk(0, 0, 0, 0, 0), "reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].q, tbl[i].v, tbl[i].clr, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Twenty breaks: feed 0 while locked at 13, then relock via 15,14,13.
    for (int i = 1; i <= 20; i++) begin
      sat = (i > 15) ? 15 : i;
      step(0, 1, 0, mk(0, 0, 2, 1, sat), $sformatf("sat_break%0d", i));
      step(15, 1, 0, mk(0, 0, 2, 1, sat), "sat_acq1");
      step(14, 1, 0, mk(0, 0, 2, 1, sat), "sat_acq2");
      step(13, 1, 0, mk(1, 0, 2, 1, sat), "sat_relock");
    end

    // Clear coinciding with a break: the break wins.
    step(0, 1, 1, mk(0, 0, 2, 1, 1), "clear_vs_break");
    step(15, 1, 0, mk(0, 0, 2, 1, 1), "clr_acq1");
    step(14, 1, 0, mk(0, 0, 2, 1, 1), "clr_acq2");
    step(13, 1, 0, mk(1, 0, 2, 1, 1), "clr_relock");
    step(12, 1, 1, mk(1, 0, 2, 0, 0), "clear_alone");

    // Asynchronous reset mid-stream, checked before any clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_now(mk(0, 0, 0, 0, 0), "async_reset_immediate");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(3, 1, 0, mk(0, 0, 0, 0, 0), "post_reset_seed");
    step(2, 1, 0, mk(0, 0, 0, 0, 0), "post_reset_acq1");
    step(1, 1, 0, mk(0, 0, 0, 0, 0), "post_reset_acq2");
    step(0, 1, 0, mk(1, 0, 0, 0, 0), "post_reset_lock_no_tc");
    step(15, 1, 0, mk(1, 0, 1, 0, 0), "post_reset_wrap");
    step(14, 1, 0, mk(1, 0, 1, 0, 0), "post_reset_hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
